// File: rtl/out_serial_queue_if.sv
// req_if: valid/ready handshake used for the issue and commit requests of out_serial_queue.
interface req_if;
  logic valid;
  logic ready;

  modport sink (input valid, output ready);
  modport source (output valid, input ready);
endinterface

// File: rtl/out_serial_queue.sv
// out_serial_queue: in-order OUT queue between issue and commit; snoops CDBs and feeds the UART sender.
// Macro OUT_WORD_MODE_EN enables 4-byte word-mode OUTs; without it every entry is a single byte.
package out_serial_queue_pkg;
  localparam int unsigned ROB_WIDTH = 4;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  function automatic logic tag_match(cdb_t c, logic [ROB_WIDTH-1:0] tag);
    return c.valid && (c.tag == tag);
  endfunction
endpackage

module out_serial_queue
  import out_serial_queue_pkg::*;
#(
  parameter int unsigned N_ENTRY = 4,
  parameter int unsigned N_CDB   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  cdb_t       gpr_read,
  input  cdb_t       gpr_cdb [N_CDB],
  input  logic       issue_word,
  req_if.sink        issue_req,
  req_if.sink        commit_req,
  input  logic       sender_ready,
  output logic       sender_valid,
  output logic [7:0] sender_in
);
  localparam int unsigned CW = $clog2(N_ENTRY) + 1;
`ifdef OUT_WORD_MODE_EN
  localparam int unsigned DW = 32;
`else
  localparam int unsigned DW = 8;
`endif

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [DW-1:0]        data;
`ifdef OUT_WORD_MODE_EN
    logic                 word;
`endif
  } entry_t;

  entry_t        e_q   [N_ENTRY];
  entry_t        e_upd [N_ENTRY];
  entry_t        e_d   [N_ENTRY];
  entry_t        new_e;
  logic [CW-1:0] count_q, count_d, slot;
  logic          head_ok, last, send, commit, issue;

  // CDB snoop of stored entries and of the issuing operand; the lowest port index wins.
  always_comb begin
    new_e.valid = gpr_read.valid;
    new_e.tag   = gpr_read.tag;
    new_e.data  = gpr_read.data[DW-1:0];
`ifdef OUT_WORD_MODE_EN
    new_e.word  = issue_word;
`endif
    for (int k = int'(N_CDB) - 1; k >= 0; k--) begin
      if (!gpr_read.valid && tag_match(gpr_cdb[k], gpr_read.tag)) begin
        new_e.valid = 1'b1;
        new_e.data  = gpr_cdb[k].data[DW-1:0];
      end
    end
    for (int unsigned i = 0; i < N_ENTRY; i++) begin
      e_upd[i] = e_q[i];
      for (int k = int'(N_CDB) - 1; k >= 0; k--) begin
        if (!e_q[i].valid && tag_match(gpr_cdb[k], e_q[i].tag)) begin
          e_upd[i].valid = 1'b1;
          e_upd[i].data  = gpr_cdb[k].data[DW-1:0];
        end
      end
    end
  end

  assign head_ok = (count_q != '0) && e_q[0].valid;

`ifdef OUT_WORD_MODE_EN
  logic [1:0] byte_idx_q, byte_idx_d;

  assign last      = e_q[0].word ? (byte_idx_q == 2'd3) : 1'b1;
  assign sender_in = e_q[0].data[{byte_idx_q, 3'b000} +: 8];

  always_comb begin
    byte_idx_d = byte_idx_q;
    if (send) byte_idx_d = last ? 2'd0 : byte_idx_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) byte_idx_q <= '0;
    else       byte_idx_q <= byte_idx_d;
  end
`else
  logic unused_bits;

  assign last      = 1'b1;
  assign sender_in = e_q[0].data[7:0];

  // Upper operand bits and the mode flag have no use in a byte-only queue.
  always_comb begin
    unused_bits = issue_word ^ (^gpr_read.data[31:8]);
    for (int unsigned k = 0; k < N_CDB; k++) unused_bits = unused_bits ^ (^gpr_cdb[k].data[31:8]);
  end
`endif

  assign sender_valid     = commit_req.valid && head_ok;
  assign send             = sender_valid && sender_ready;
  assign commit_req.ready = sender_ready && head_ok && last;
  assign commit           = commit_req.valid && commit_req.ready;
  assign issue_req.ready  = commit || (count_q < CW'(N_ENTRY));
  assign issue            = issue_req.valid && issue_req.ready;

  // Shift on commit; the new entry lands just behind the last occupied slot.
  always_comb begin
    slot    = commit ? count_q - CW'(1) : count_q;
    count_d = count_q;
    if (commit && !issue)      count_d = count_q - CW'(1);
    else if (issue && !commit) count_d = count_q + CW'(1);
    for (int unsigned i = 0; i < N_ENTRY; i++) begin
      e_d[i] = commit ? e_upd[(i + 1) % N_ENTRY] : e_upd[i];
      if (issue && (slot == CW'(i))) e_d[i] = new_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_ENTRY; i++) e_q[i] <= e_d[i];
  end
endmodule

// File: tb/tb_out_serial_queue.sv
// tb_out_serial_queue: directed and randomized checks of out_serial_queue against a queue-based model.
module tb_out_serial_queue;
  import out_serial_queue_pkg::*;

  localparam int unsigned N_ENTRY = 4;
  localparam int unsigned N_CDB   = 2;
`ifdef OUT_WORD_MODE_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  cdb_t       gpr_read;
  cdb_t       gpr_cdb [N_CDB];
  logic       issue_word;
  logic       sender_ready;
  logic       sender_valid;
  logic [7:0] sender_in;

  req_if issue_req ();
  req_if commit_req ();

  always #5 clk = ~clk;

  out_serial_queue #(.N_ENTRY(N_ENTRY), .N_CDB(N_CDB)) dut (
    .clk          (clk),
    .reset        (reset),
    .gpr_read     (gpr_read),
    .gpr_cdb      (gpr_cdb),
    .issue_word   (issue_word),
    .issue_req    (issue_req),
    .commit_req   (commit_req),
    .sender_ready (sender_ready),
    .sender_valid (sender_valid),
    .sender_in    (sender_in)
  );

  typedef struct {
    bit                 valid;
    bit [ROB_WIDTH-1:0] tag;
    bit [31:0]          data;
    bit                 word;
  } m_entry_t;

  m_entry_t    mq[$];
  int unsigned mbyte;
  int          total;
  int          bad;
  bit          exp_commit, exp_issue, exp_send, exp_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // An unresolved operand picks up the first matching broadcast.
  function automatic m_entry_t resolve(m_entry_t e);
    m_entry_t r = e;
    if (!r.valid) begin
      for (int k = 0; k < int'(N_CDB); k++) begin
        if (gpr_cdb[k].valid && gpr_cdb[k].tag == r.tag) begin
          r.valid = 1'b1;
          r.data  = gpr_cdb[k].data;
          return r;
        end
      end
    end
    return r;
  endfunction

  task automatic idle();
    reset             = 1'b0;
    gpr_read          = '0;
    issue_word        = 1'b0;
    issue_req.valid   = 1'b0;
    commit_req.valid  = 1'b0;
    sender_ready      = 1'b0;
    for (int k = 0; k < int'(N_CDB); k++) gpr_cdb[k] = '0;
  endtask

  task automatic put(input bit v, input int unsigned tag, input logic [31:0] d, input bit w);
    issue_req.valid = 1'b1;
    gpr_read.valid  = v;
    gpr_read.tag    = ROB_WIDTH'(tag);
    gpr_read.data   = d;
    issue_word      = w;
  endtask

  task automatic apply_and_check();
    bit       hv, sv, cr, ir;
    bit [7:0] b;
    #1;
    hv = (mq.size() != 0) ? mq[0].valid : 1'b0;
    exp_last = 1'b1;
    if (hv && mq[0].word) exp_last = (mbyte == 3);
    sv = commit_req.valid && hv;
    cr = sender_ready && hv && exp_last;
    exp_commit = commit_req.valid && cr;
    ir = exp_commit || (mq.size() < N_ENTRY);
    exp_issue = issue_req.valid && ir;
    exp_send = sv && sender_ready;
    check("sender_valid", 32'(sender_valid), 32'(sv));
    check("commit_ready", 32'(commit_req.ready), 32'(cr));
    check("issue_ready", 32'(issue_req.ready), 32'(ir));
    if (sv) begin
      b = 8'(mq[0].data >> (8 * mbyte));
      check("sender_in", 32'(sender_in), 32'(b));
    end
  endtask

  task automatic advance();
    m_entry_t n;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      mbyte = 0;
    end else begin
      for (int i = 0; i < mq.size(); i++) mq[i] = resolve(mq[i]);
      if (exp_send) mbyte = exp_last ? 0 : mbyte + 1;
      if (exp_commit) void'(mq.pop_front());
      if (exp_issue) begin
        n.valid = gpr_read.valid;
        n.tag   = gpr_read.tag;
        n.data  = gpr_read.data;
        n.word  = WORD_EN && issue_word;
        mq.push_back(resolve(n));
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    apply_and_check();
    advance();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mbyte = 0;
    idle();
    reset = 1'b1;
    @(negedge clk);
    step();
    step();

    idle();
    commit_req.valid = 1'b1;
    sender_ready     = 1'b1;
    apply_and_check();
    check("rst_sender_valid", 32'(sender_valid), 32'd0);
    check("rst_commit_ready", 32'(commit_req.ready), 32'd0);
    advance();

    // byte OUT with a valid operand completes in one cycle
    idle(); put(1'b1, 0, 32'h41, 1'b0); step();
    idle(); commit_req.valid = 1'b1; sender_ready = 1'b1;
    apply_and_check();
    check("byte41_data", 32'(sender_in), 32'h41);
    check("byte41_commit", 32'(commit_req.ready), 32'd1);
    advance();
    idle(); commit_req.valid = 1'b1; sender_ready = 1'b1;
    apply_and_check();
    check("byte41_empty", 32'(sender_valid), 32'd0);
    advance();

    // word OUT with a stall on the second byte
    idle(); put(1'b1, 0, 32'h44434241, 1'b1); step();
`ifdef OUT_WORD_MODE_EN
    begin
      bit [7:0] wb [5] = '{8'h41, 8'h42, 8'h42, 8'h43, 8'h44};
      bit       wr [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      bit       wc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
        idle(); commit_req.valid = 1'b1; sender_ready = wr[i];
        apply_and_check();
        check("word_byte", 32'(sender_in), 32'(wb[i]));
        check("word_commit", 32'(commit_req.ready), 32'(wc[i]));
        advance();
      end
    end
`else
    idle(); commit_req.valid = 1'b1; sender_ready = 1'b1;
    apply_and_check();
    check("word_as_byte", 32'(sender_in), 32'h41);
    check("word_as_byte_commit", 32'(commit_req.ready), 32'd1);
    advance();
`endif

    // operand arrives later on CDB port 1
    idle(); put(1'b0, 5, 32'h0, 1'b0); step();
    idle(); commit_req.valid = 1'b1; sender_ready = 1'b1;
    gpr_cdb[1] = '{valid: 1'b1, tag: ROB_WIDTH'(5), data: 32'h7A};
    apply_and_check();
    check("tag5_wait", 32'(sender_valid), 32'd0);
    advance();
    idle(); commit_req.valid = 1'b1; sender_ready = 1'b1;
    apply_and_check();
    check("tag5_wake", 32'(sender_valid), 32'd1);
    check("tag5_data", 32'(sender_in), 32'h7A);
    advance();

    // same-cycle bypass at issue
    idle(); put(1'b0, 6, 32'h0, 1'b0);
    gpr_cdb[0] = '{valid: 1'b1, tag: ROB_WIDTH'(6), data: 32'h55};
    step();
    idle(); commit_req.valid = 1'b1; sender_ready = 1'b1;
    apply_and_check();
    check("bypass_valid", 32'(sender_valid), 32'd1);
    check("bypass_data", 32'(sender_in), 32'h55);
    advance();

    // fill, then issue and commit together while full
    for (int i = 0; i < 4; i++) begin
      idle(); put(1'b1, 0, 32'h10 + 32'(i), 1'b0); step();
    end
    idle(); put(1'b1, 0, 32'h99, 1'b0);
    apply_and_check();
    check("full_ready", 32'(issue_req.ready), 32'd0);
    advance();
    idle(); put(1'b1, 0, 32'h14, 1'b0); commit_req.valid = 1'b1; sender_ready = 1'b1;
    apply_and_check();
    check("full_commit_ready", 32'(issue_req.ready), 32'd1);
    check("full_head", 32'(sender_in), 32'h10);
    advance();
    for (int i = 1; i <= 4; i++) begin
      idle(); commit_req.valid = 1'b1; sender_ready = 1'b1;
      apply_and_check();
      check("drain_order", 32'(sender_in), 32'h10 + 32'(i));
      advance();
    end

    // reset in the middle of a word
    idle(); put(1'b1, 0, 32'hA1B2C3D4, 1'b1); step();
    for (int i = 0; i < 2; i++) begin
      idle(); commit_req.valid = 1'b1; sender_ready = 1'b1; step();
    end
    idle(); put(1'b1, 0, 32'h5A, 1'b1); reset = 1'b1; commit_req.valid = 1'b1; sender_ready = 1'b1; step();
    idle(); commit_req.valid = 1'b1; sender_ready = 1'b1;
    apply_and_check();
    check("rst_mid_valid", 32'(sender_valid), 32'd0);
    advance();
    idle(); put(1'b1, 0, 32'h66, 1'b0); step();
    idle(); commit_req.valid = 1'b1; sender_ready = 1'b1;
    apply_and_check();
    check("rst_fresh_byte", 32'(sender_in), 32'h66);
    check("rst_fresh_commit", 32'(commit_req.ready), 32'd1);
    advance();

`ifndef OUT_WORD_MODE_EN
    // word flag ignored in a byte-only build
    idle(); put(1'b1, 0, 32'h1234, 1'b1); step();
    idle(); commit_req.valid = 1'b1; sender_ready = 1'b1;
    apply_and_check();
    check("byteonly_data", 32'(sender_in), 32'h34);
    check("byteonly_commit", 32'(commit_req.ready), 32'd1);
    advance();
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      reset = ($urandom_range(99) == 0);
      if ($urandom_range(1) == 1)
        put($urandom_range(1) == 1, $urandom_range(15), $urandom(), $urandom_range(1) == 1);
      for (int k = 0; k < int'(N_CDB); k++) begin
        gpr_cdb[k].valid = ($urandom_range(9) < 3);
        gpr_cdb[k].tag   = ROB_WIDTH'($urandom_range(15));
        gpr_cdb[k].data  = $urandom();
      end
      commit_req.valid = ($urandom_range(9) < 7);
      sender_ready     = ($urandom_range(9) < 7);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
